// File: rtl/soc_pkg.sv
// Shared constants, UART transmitter state type and baud-divisor helper for the bring-up SoC.
package soc_pkg;

  localparam logic [31:0] LED_ADDR  = 32'h1000_0000;
  localparam logic [31:0] UART_ADDR = 32'h1000_0004;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Cycles per UART bit, truncating.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/picorv32.sv
// Fetch-only stand-in exposing picorv32's native memory interface and parameters.
// The full core replaces this file in integrated builds.
module picorv32 #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter logic [31:0] STACKADDR      = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  logic        halted_q;
  logic [31:0] stack_unused;

  assign stack_unused = STACKADDR;
  assign mem_instr    = 1'b1;
  assign mem_wdata    = 32'h0;
  assign mem_wstrb    = 4'b0000;

  // Sequential fetch from the reset vector; an all-zero word is illegal and halts fetching.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr  <= PROGADDR_RESET;
      halted_q  <= 1'b0;
    end else if (!halted_q) begin
      mem_valid <= 1'b1;
      if (mem_valid && mem_ready) begin
        if (mem_rdata == 32'h0) begin
          halted_q  <= 1'b1;
          mem_valid <= 1'b0;
        end else begin
          mem_addr <= mem_addr + 32'd4;
        end
      end
    end
  end

endmodule

// File: rtl/soc_uart_tx.sv
// Buffered UART 8N1 transmitter: byte FIFO feeding a bit serialiser that sends frames back-to-back.
module uart_tx_fifo
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       uart_tx
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] CntLast   = CntW'(BIT_CYCLES - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            empty, full, do_push, do_pop, bit_end;

  uart_state_e     state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign do_push = push & ~full;
  assign bit_end = (baud_cnt_q == CntLast);
  // Popping at the end of a stop bit chains the next frame with no idle gap.
  assign do_pop  = ~empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      uart_tx    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (do_pop) begin
            state_q    <= StStart;
            baud_cnt_q <= '0;
            shift_q    <= mem_q[rd_ptr_q];
            uart_tx    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q    <= StData;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            uart_tx    <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              uart_tx <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              uart_tx   <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (do_pop) begin
              state_q <= StStart;
              shift_q <= mem_q[rd_ptr_q];
              uart_tx <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/soc_top.sv
// Bring-up SoC top: core, native bus decode, LED register and buffered UART transmitter.
// Program RAM lives outside and drives mem_rdata/mem_ready directly.
module soc_top
  import soc_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STACK_ADDR   = 32'h0001_0000,
  parameter logic [31:0] LED_ADDR     = soc_pkg::LED_ADDR,
  parameter logic [31:0] UART_ADDR    = soc_pkg::UART_ADDR,
  parameter int unsigned TXFIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] led
);

  localparam int unsigned BitCycles = baud_div(CLK_FREQ, BAUD);

  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [1:0]  rst_sync_q;
  logic        sys_rst, core_resetn;
  logic [1:0]  rx_sync_q;
  logic        wr_acc, led_we, uart_we;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        unused_sigs;

  // Assert immediately, release two edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign sys_rst     = rst_sync_q[1];
  assign core_resetn = ~sys_rst;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) rx_sync_q <= 2'b11;
    else         rx_sync_q <= {rx_sync_q[0], uart_rx};
  end

  picorv32 #(
    .PROGADDR_RESET(RESET_ADDR),
    .STACKADDR     (STACK_ADDR)
  ) u_core (
    .clk      (clk),
    .resetn   (core_resetn),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  assign wr_acc  = mem_valid & mem_ready & (mem_wstrb != 4'b0000);
  assign led_we  = wr_acc & mem_wstrb[0] & (mem_addr == LED_ADDR);
  assign uart_we = wr_acc & mem_wstrb[0] & (mem_addr == UART_ADDR);

  // uart_tx_valid strobes on every accepted UART write, even when the FIFO drops the byte.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      led           <= 8'h00;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      if (led_we) led <= mem_wdata[7:0];
      uart_tx_valid <= uart_we;
      if (uart_we) uart_tx_data <= mem_wdata[7:0];
    end
  end

  uart_tx_fifo #(
    .DEPTH     (TXFIFO_DEPTH),
    .BIT_CYCLES(BitCycles)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (sys_rst),
    .push     (uart_we),
    .push_data(mem_wdata[7:0]),
    .uart_tx  (uart_tx)
  );

  assign unused_sigs = ^{mem_instr, mem_wdata[31:8], rx_sync_q[1]};

endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: drives the internal bus nets, checks LED/UART behaviour against a frame-level model.
module tb_soc_top;

  localparam int unsigned BitCycles   = 50_000_000 / 115200;
  localparam int unsigned FrameCycles = 10 * BitCycles;
  localparam logic [31:0] LedAddr     = 32'h1000_0000;
  localparam logic [31:0] UartAddr    = 32'h1000_0004;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] led;

  logic        bus_valid = 1'b0, bus_ready = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;

  int compared = 0, mismatched = 0;
  logic checking = 1'b0;
  int t, n, lows;
  logic [9:0] fr;
  logic [9:0] h_bits;

  soc_top dut (
    .clk    (clk),
    .rst    (rst),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .led    (led)
  );

  always #5 clk = ~clk;

  initial begin
    force dut.mem_ready = bus_ready;
    force dut.mem_rdata = 32'h0000_0013;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_q[$];
  logic         m_busy;
  int           m_pos, m_rel, m_sz;
  logic [9:0]   m_frame;
  logic [7:0]   m_led, m_data;
  logic         m_valid, m_wr_uart, m_wr_led;

  function automatic logic model_tx();
    return m_busy ? m_frame[m_pos / BitCycles] : 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rel = 0; m_q.delete(); m_busy = 0; m_pos = 0;
      m_led = 8'h00; m_valid = 0; m_data = 8'h00;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      m_sz      = m_q.size();
      m_wr_uart = bus_valid & bus_ready & bus_wstrb[0] & (bus_addr == UartAddr);
      m_wr_led  = bus_valid & bus_ready & bus_wstrb[0] & (bus_addr == LedAddr);
      if (m_busy) begin
        m_pos++;
        if (m_pos == FrameCycles) begin
          if (m_q.size() > 0) begin
            m_frame = {1'b1, m_q.pop_front(), 1'b0};
            m_pos   = 0;
          end else begin
            m_busy = 0;
          end
        end
      end else if (m_sz > 0) begin
        m_frame = {1'b1, m_q.pop_front(), 1'b0};
        m_busy  = 1;
        m_pos   = 0;
      end
      if (m_wr_uart && m_sz < 16) m_q.push_back(bus_wdata[7:0]);
      m_valid = m_wr_uart;
      if (m_wr_uart) m_data = bus_wdata[7:0];
      if (m_wr_led)  m_led  = bus_wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cyc_uart_tx", uart_tx, model_tx());
      check("cyc_led", led, m_led);
      check("cyc_tx_valid", dut.uart_tx_valid, m_valid);
      if (m_valid) check("cyc_tx_data", dut.uart_tx_data, m_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_addr = a; bus_wdata = d; bus_wstrb = s; bus_valid = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0; bus_ready = 1'b0; bus_wstrb = 4'b0000;
  endtask

  task automatic wait_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    // Reset and first fetch
    repeat (5) begin
      @(negedge clk);
      check("rst_uart_tx", uart_tx, 1'b1);
      check("rst_led", led, 8'h00);
    end
    rst = 1'b0;
    checking = 1'b1;
    n = 0;
    while (dut.mem_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_valid", dut.mem_valid, 1'b1);
    check("fetch_addr", dut.mem_addr, 32'h0000_0000);
    check("fetch_instr", dut.mem_instr, 1'b1);

    force dut.mem_valid = bus_valid;
    force dut.mem_instr = 1'b0;
    force dut.mem_addr  = bus_addr;
    force dut.mem_wdata = bus_wdata;
    force dut.mem_wstrb = bus_wstrb;
    @(negedge clk);

    // LED register
    bus_write(LedAddr, 32'h0000_00A5, 4'b0001);
    check("led_write", led, 8'hA5);
    bus_write(LedAddr, 32'h0000_3C00, 4'b0010);
    check("led_wstrb_byte1", led, 8'hA5);
    bus_write(32'h1000_0008, 32'h0000_0011, 4'b0001);
    check("other_addr_led", led, 8'hA5);
    check("other_addr_valid", dut.uart_tx_valid, 1'b0);

    // Single byte 'H'
    h_bits = 10'b1_0100_1000_0;
    bus_write(UartAddr, 32'h0000_0048, 4'b0001);
    check("h_valid", dut.uart_tx_valid, 1'b1);
    check("h_data", dut.uart_tx_data, 8'h48);
    check("h_idle_before_start", uart_tx, 1'b1);
    @(negedge clk);
    check("h_valid_one_cycle", dut.uart_tx_valid, 1'b0);
    check("h_start_edge", uart_tx, 1'b0);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      wait_to(k * BitCycles + BitCycles / 2);
      check("h_bit", uart_tx, h_bits[k]);
    end
    wait_to(FrameCycles + 5);
    check("h_idle_after", uart_tx, 1'b1);

    // Burst of 18 writes: 17 fit (one pops at once), the 18th is dropped
    for (int i = 0; i < 18; i++) begin
      bus_write(UartAddr, 32'h41 + i, 4'b0001);
      check("burst_valid", dut.uart_tx_valid, 1'b1);
      check("burst_data", dut.uart_tx_data, 8'h41 + 8'(i));
    end
    t = 16;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 10; k++) begin
        wait_to(i * FrameCycles + k * BitCycles + BitCycles / 2);
        fr[k] = uart_tx;
      end
      check("burst_byte", fr[8:1], 8'h41 + 8'(i));
      check("burst_framing", {fr[9], fr[0]}, 2'b10);
    end
    wait_to(17 * FrameCycles + BitCycles / 2);
    check("burst_no_18th", uart_tx, 1'b1);
    repeat (BitCycles) @(negedge clk);

    // Reset in the middle of a frame, with a second byte still queued
    bus_write(LedAddr, 32'h0000_005A, 4'b0001);
    check("led_5a", led, 8'h5A);
    bus_write(UartAddr, 32'h0000_0055, 4'b0001);
    bus_write(UartAddr, 32'h0000_0066, 4'b0001);
    repeat (2 * BitCycles + BitCycles / 2) @(negedge clk);
    check("mid_frame_data_bit", uart_tx, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_async_uart_tx", uart_tx, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_mid_led", led, 8'h00);
    rst = 1'b0;
    lows = 0;
    repeat (600) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_no_frames", lows, 0);
    check("post_rst_led", led, 8'h00);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_500_000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Minimal RISC-V SoC top for FreeRTOS bring-up.
- Instantiates the codebase's existing picorv32 core (not counted in this block) and adds:
  - a single-master native memory bus exposed as internal nets,
  - address decode,
  - an 8-bit LED output register,
  - a buffered UART 8N1 transmitter.
- Program RAM is supplied by the environment on the internal bus nets. The block contains no RAM.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD, 115200, UART bit rate; bit period = CLK_FREQ/BAUD cycles (integer divide, 434 at defaults).
- RESET_ADDR, 32'h0000_0000, core reset PC.
- STACK_ADDR, 32'h0001_0000, initial stack pointer (top of 64 KiB RAM).
- LED_ADDR, 32'h1000_0000, LED register address.
- UART_ADDR, 32'h1000_0004, UART TX data address.
- TXFIFO_DEPTH, 16, UART transmit FIFO entries (power of two).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial receive line; double-flop synchronised, otherwise reserved (no function).
- uart_tx  out  1  serial transmit line, idle high.
- led  out  8  LED register value.

Behaviour:
- Reset handling:
  - rst asserts asynchronously and deasserts through a 2-flop synchroniser.
  - Core resetn = ~synchronised reset.
- Outputs during reset: uart_tx=1, led=8'h00, FIFO empty, transmitter idle, uart_tx_valid=0.
- Internal bus nets, with fixed names used by benches: mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0], mem_rdata[31:0], mem_ready.
  - Core drives mem_valid, mem_instr, mem_addr, mem_wdata and mem_wstrb.
  - mem_rdata and mem_ready are declared in soc_top but not driven by it; the memory environment drives them.
- Write acceptance: a write is accepted in a cycle where mem_valid & mem_ready & (mem_wstrb != 0).
- LED write: accepted write with mem_addr==LED_ADDR and mem_wstrb[0]=1 sets led <= mem_wdata[7:0] on that edge.
- UART write: accepted write with mem_addr==UART_ADDR and mem_wstrb[0]=1:
  - if FIFO not full, pushes mem_wdata[7:0];
  - if FIFO full, the byte is dropped silently.
- Debug strobe on every accepted UART write, including dropped ones:
  - uart_tx_valid (internal, 1 bit) is registered high for exactly one cycle;
  - uart_tx_data[7:0] (internal) holds that byte in the same cycle.
- Other writes: writes to other addresses, or with wstrb[0]=0, leave peripheral state unchanged. Reads of peripheral addresses return whatever the environment drives.
- Transmitter FSM (IDLE, START, DATA, STOP), baud counter counts 0..CLK_FREQ/BAUD-1:
  - IDLE: uart_tx=1. If FIFO not empty, pop a byte and go to START on the next edge.
  - START: uart_tx=0 for one bit period.
  - DATA: 8 bits LSB first, one bit period each.
  - STOP: uart_tx=1 for one bit period, then IDLE.
  - Consecutive bytes are sent back-to-back with no extra idle.
- FIFO: push and pop in the same cycle are both honoured. Count saturates at TXFIFO_DEPTH; pointers wrap modulo depth.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously) and FIFO contents are discarded.

Decomposition:
- Package soc_pkg holds:
  - address constants LED_ADDR and UART_ADDR,
  - the uart_state_e enum (IDLE/START/DATA/STOP),
  - the baud-divisor function.
- Natural sub-module: uart_tx_fifo, containing the FIFO plus the 8N1 serialiser. Decode, LED register, reset synchroniser and core instance stay in soc_top.

Test Plan:
1. Apply rst for 5 cycles then release -> led=0x00 and uart_tx=1 throughout; core's first mem_valid has mem_addr=0x0000_0000 and mem_instr=1.
2. Bench forces write LED_ADDR, wdata=0x000000A5, wstrb=4'b0001 -> led=0xA5 one edge later. Repeat with wstrb=4'b0010 -> led unchanged.
3. Write 0x48 ('H') to UART_ADDR -> uart_tx_valid high for one cycle with uart_tx_data=0x48. uart_tx then shows:
   - low for 434 cycles,
   - bits 0,0,0,1,0,0,1,0 at 434 cycles each,
   - high stop bit.
4. 17 back-to-back UART writes 0x41..0x51 while idle -> 17 uart_tx_valid pulses. The first byte pops immediately, so 16 fit in the FIFO and all 17 are serialised in order with no gaps. An 18th write during the burst is dropped.
5. Assert rst during the DATA state of a frame -> uart_tx=1 within the same cycle, no further frames after release, led=0x00.
